// File: rtl/mem_sched_pkg.sv
`default_nettype none
// ============================================================================
// mem_sched_pkg : shared constants and FSM state type for mem_sched
// Rev 1.0
// ============================================================================
package mem_sched_pkg;

  localparam logic [2:0] CMD_WR    = 3'b000;
  localparam logic [2:0] CMD_RD    = 3'b001;
  localparam int         PIX_W     = 27;
  localparam int         LANE_W    = 32;
  localparam int         LANES     = 8;
  localparam int         ADDR_STEP = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_sched_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with first-word fall-through read data
// Rev 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_depth);
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
      if (w_rd) r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_sched.sv
`default_nettype none
// ============================================================================
// mem_sched : packs/unpacks 27-bit pixels into 256-bit DDR3 bursts and
//             arbitrates the app command port over a circular frame buffer
// Rev 1.0
// ============================================================================
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 29,
  parameter int APP_DATA_WIDTH = 256,
  parameter int FRAME_WORDS    = 259200,
  parameter int RD_DEPTH       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      vin_val_i,
  output logic                      vin_rdy_o,
  input  logic [PIX_W-1:0]          vin_data_i,
  output logic                      vout_val_o,
  input  logic                      vout_rdy_i,
  output logic [PIX_W-1:0]          vout_data_o,
  output logic [ADDR_WIDTH-1:0]     app_addr_o,
  output logic [2:0]                app_cmd_o,
  output logic                      app_en_o,
  input  logic                      app_rdy_i,
  output logic [APP_DATA_WIDTH-1:0] app_wdf_data_o,
  output logic                      app_wdf_wren_o,
  output logic                      app_wdf_end_o,
  input  logic                      app_wdf_rdy_i,
  input  logic [APP_DATA_WIDTH-1:0] app_rd_data_i,
  input  logic                      app_rd_data_valid_i
);

  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(RD_DEPTH + 1);
  localparam logic [LW-1:0]         c_last_lane = LW'(LANES - 1);
  localparam logic [CW-1:0]         c_cred_max  = CW'(RD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_step      = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'((FRAME_WORDS - 1) * ADDR_STEP);

  state_t                    r_state, w_next;
  logic                      r_alive, r_full, r_cmd_done, r_dat_done, r_rd_go, r_last_wr;
  logic [LW-1:0]             r_wcnt, r_rcnt;
  logic [APP_DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0]     r_waddr, r_raddr, r_addr;
  logic [2:0]                r_cmd;
  logic [CW-1:0]             r_credits;

  logic w_vin_hs, w_last_pix, w_wr_pend, w_rd_pend;
  logic w_cmd_hs, w_wr_acc, w_rd_acc, w_dat_hs, w_cmd_fin, w_dat_fin;
  logic w_vout_hs, w_pop, w_buf_empty, w_buf_full, w_unused;
  logic [APP_DATA_WIDTH-1:0] w_head;

  assign vin_rdy_o  = r_alive & ~r_full;
  assign w_vin_hs   = vin_val_i & vin_rdy_o;
  assign w_last_pix = w_vin_hs & (r_wcnt == c_last_lane);
  // Lookahead on the last pixel lets the write grant land one cycle after it.
  assign w_wr_pend  = (r_full & ~r_cmd_done) | w_last_pix;
  assign w_rd_pend  = r_rd_go & (r_credits < c_cred_max);

  assign app_en_o       = (r_state != ST_IDLE);
  assign app_addr_o     = r_addr;
  assign app_cmd_o      = r_cmd;
  assign app_wdf_data_o = r_wdata;
  assign app_wdf_wren_o = r_full & ~r_dat_done;
  assign app_wdf_end_o  = app_wdf_wren_o;

  assign w_cmd_hs  = app_en_o & app_rdy_i;
  assign w_wr_acc  = w_cmd_hs & (r_state == ST_WR);
  assign w_rd_acc  = w_cmd_hs & (r_state == ST_RD);
  assign w_dat_hs  = app_wdf_wren_o & app_wdf_rdy_i;
  assign w_cmd_fin = r_cmd_done | w_wr_acc;
  assign w_dat_fin = r_dat_done | w_dat_hs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alive    <= 1'b0;
      r_wcnt     <= '0;
      r_wdata    <= '0;
      r_full     <= 1'b0;
      r_cmd_done <= 1'b0;
      r_dat_done <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_vin_hs) begin
        r_wdata[r_wcnt*LANE_W +: LANE_W] <= LANE_W'(vin_data_i);
        r_wcnt <= r_wcnt + 1'b1;
        if (w_last_pix) r_full <= 1'b1;
      end
      if (r_full & w_cmd_fin & w_dat_fin) begin
        r_full     <= 1'b0;
        r_cmd_done <= 1'b0;
        r_dat_done <= 1'b0;
      end else begin
        if (w_wr_acc) r_cmd_done <= 1'b1;
        if (w_dat_hs) r_dat_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_wr_pend && w_rd_pend) w_next = r_last_wr ? ST_RD : ST_WR;
        else if (w_wr_pend)         w_next = ST_WR;
        else if (w_rd_pend)         w_next = ST_RD;
      end
      ST_WR, ST_RD: if (app_rdy_i) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Command fields are latched at grant so app_addr_o never follows app_rdy_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr    <= '0;
      r_cmd     <= CMD_WR;
      r_last_wr <= 1'b0;
    end else if (r_state == ST_IDLE && w_next == ST_WR) begin
      r_addr    <= r_waddr;
      r_cmd     <= CMD_WR;
      r_last_wr <= 1'b1;
    end else if (r_state == ST_IDLE && w_next == ST_RD) begin
      r_addr    <= r_raddr;
      r_cmd     <= CMD_RD;
      r_last_wr <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_rd_go <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        if (r_waddr == c_last_addr) begin
          r_waddr <= '0;
          r_rd_go <= 1'b1;
        end else begin
          r_waddr <= r_waddr + c_step;
        end
      end
      if (w_rd_acc) r_raddr <= (r_raddr == c_last_addr) ? '0 : r_raddr + c_step;
    end
  end

  assign vout_val_o  = ~w_buf_empty;
  assign vout_data_o = w_head[r_rcnt*LANE_W +: PIX_W];
  assign w_vout_hs   = vout_val_o & vout_rdy_i;
  assign w_pop       = w_vout_hs & (r_rcnt == c_last_lane);
  assign w_unused    = ^{w_buf_full, w_head};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rcnt    <= '0;
      r_credits <= '0;
    end else begin
      if (w_vout_hs) r_rcnt <= r_rcnt + 1'b1;
      case ({w_rd_acc, w_pop})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (APP_DATA_WIDTH),
    .DEPTH (RD_DEPTH)
  ) u_rd_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (app_rd_data_valid_i),
    .i_din   (app_rd_data_i),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_buf_empty),
    .o_full  (w_buf_full)
  );

endmodule
`default_nettype wire
